game_status_ctrl: RTL
=====================

Name: game_status_ctrl

Overview:
- Sequential game-flow controller. It consumes the per-frame door-overlap flags `is_win_girl`/`is_win_boy` and the death flag, plus the keyboard keycode.
- It produces the one-hot 4-bit `status` bus that the screen renderers decode (`4'b0100` selects the win screen).
- It sits between the character/collision logic and the color-mapper and screen-ROM path, in the top level next to the ball/character controllers.

Parameters:
- WIN_HOLD_FRAMES, 30, consecutive frames both players must stand in their doors before WIN is declared (range 1..255).
- FRAMES_PER_SEC, 60, frame ticks per elapsed-time second (optional timer only).
- START_KEY, 8'h28, USB keycode (Enter) that starts or restarts the game.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VGA vertical-sync-derived frame clock, synchronous to Clk.
- keycode  in  8  current USB keycode, 8'h00 when no key is pressed.
- is_win_girl  in  1  girl fully inside her door.
- is_win_boy  in  1  boy fully inside his door.
- is_dead  in  1  any player touched a hazard.
- status  out  4  one-hot game state: 0001 START, 0010 PLAY, 0100 WIN, 1000 DEAD.
- game_reset  out  1  one-Clk pulse that re-initialises character positions.
- play_seconds  out  10  elapsed play time in seconds (see Optional Feature).

Behaviour:
- Reset (async, active-high) values:
  - status = 4'b0001; game_reset = 0; play_seconds = 0.
  - Hold counter, frame sub-counter and edge registers all 0.
- Frame tick: register frame_clk each Clk; tick = frame_clk & ~frame_clk_q. This is a one-Clk pulse on the rising edge.
- Win/dead flags are sampled only on tick cycles; they are ignored between ticks.
- Key press: register (keycode == START_KEY) each Clk; press = match & ~match_q. A held key produces exactly one press.
- START state:
  - On press, go to PLAY next cycle and assert game_reset for exactly that one cycle (the cycle status first reads 0010).
  - The hold counter is cleared on entry to PLAY.
- PLAY state, on each tick:
  - If is_dead, go to DEAD. Death has priority over win when both are true on the same tick.
  - Else if is_win_girl & is_win_boy: if hold_cnt == WIN_HOLD_FRAMES-1, go to WIN; else hold_cnt += 1.
  - Else hold_cnt = 0. A single frame with either flag low restarts the count.
  - With WIN_HOLD_FRAMES=1, WIN is reached on the first qualifying tick.
  - A press in PLAY is ignored.
- WIN and DEAD: on press, go to START. Ticks and flags are ignored; status holds.
- The status register changes only on a Clk edge. Latency from the qualifying tick cycle to the new status is 1 Clk.
- hold_cnt width is $clog2(WIN_HOLD_FRAMES+1). It saturates and never wraps.
- A tick and a press in the same cycle are each handled by the state they apply to. No state consumes both.
- Reset asserted mid-game forces START immediately, regardless of Clk.
- status is always exactly one-hot. Any illegal encoding returns to START on the next Clk.

Optional Feature:
- Macro: GAME_TIMER_EN.
- Defined:
  - Frame sub-counter counts ticks while in PLAY. At FRAMES_PER_SEC-1 it wraps to 0 and play_seconds increments, saturating at 999.
  - play_seconds freezes in WIN and DEAD.
  - Both counters clear on the game_reset cycle.
- Undefined: play_seconds is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package `game_pkg`:
  - typedef enum logic [3:0] status_t {ST_START=4'b0001, ST_PLAY=4'b0010, ST_WIN=4'b0100, ST_DEAD=4'b1000}.
  - Localparam KEY_ENTER = 8'h28.
  - The existing renderers (including the win-screen logic) switch to these constants.
- One natural sub-module, `edge_pulse`: register plus rising-edge detect. It is instantiated twice, once for frame_clk and once for the key match.

Test Plan:
1. Reset, then keycode=8'h28 held for 100 Clk → status goes 0001→0010 once; game_reset high exactly 1 cycle; key release and re-press in PLAY leaves status 0010.
2. In PLAY, both win flags high for 29 ticks then girl low on tick 30, then both high for 30 ticks → status stays 0010 through the first run; becomes 0100 one Clk after the 30th tick of the second run.
3. In PLAY with hold_cnt=10, is_dead and both win flags high on the same tick → status = 1000.
4. In WIN, press Enter → status 0001; press again → 0010 with game_reset pulse; hold_cnt is 0 (verify with 29 qualifying ticks → still 0010).
5. Assert Reset asynchronously between Clk edges while in PLAY → status = 0001 before the next Clk edge.
6. GAME_TIMER_EN defined, FRAMES_PER_SEC=60: 150 ticks in PLAY → play_seconds = 2; enter WIN, 120 more ticks → play_seconds stays 2.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow encodings used by the status controller and the screen renderers.
// status_t is one-hot so renderers can decode a single bit per screen.
package game_pkg;

  typedef enum logic [3:0] {
    ST_START = 4'b0001,
    ST_PLAY  = 4'b0010,
    ST_WIN   = 4'b0100,
    ST_DEAD  = 4'b1000
  } status_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;

endpackage

// File: rtl/edge_pulse.sv
// Registers a level each clock and emits a one-cycle pulse on its rising edge.
// The pulse is combinational from d, so it coincides with the first cycle d is high.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_status_ctrl.sv
// Game-flow FSM: START -> PLAY -> WIN/DEAD -> START, driven by frame ticks and Enter presses.
// Optional elapsed-play-time counter is enabled with the GAME_TIMER_EN macro.
module game_status_ctrl
  import game_pkg::*;
#(
  parameter int         WIN_HOLD_FRAMES = 30,
  parameter int         FRAMES_PER_SEC  = 60,
  parameter logic [7:0] START_KEY       = KEY_ENTER
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       is_win_girl,
  input  logic       is_win_boy,
  input  logic       is_dead,
  output logic [3:0] status,
  output logic       game_reset,
  output logic [9:0] play_seconds
);

  localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(WIN_HOLD_FRAMES);

  logic          tick;
  logic          press;
  status_t       state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          game_reset_d;

  edge_pulse u_frame_edge (
    .clk   (Clk),
    .rst   (Reset),
    .d     (frame_clk),
    .pulse (tick)
  );

  edge_pulse u_key_edge (
    .clk   (Clk),
    .rst   (Reset),
    .d     (keycode == START_KEY),
    .pulse (press)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_START;
      hold_cnt   <= '0;
      game_reset <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_d;
      game_reset <= game_reset_d;
    end
  end

  always_comb begin
    state_d      = state;
    hold_d       = hold_cnt;
    game_reset_d = 1'b0;
    case (state)
      ST_START: begin
        if (press) begin
          state_d      = ST_PLAY;
          hold_d       = '0;
          game_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // Death is checked first so a simultaneous win never escapes a hazard.
        if (tick) begin
          if (is_dead) begin
            state_d = ST_DEAD;
          end else if (is_win_girl && is_win_boy) begin
            if (hold_cnt == HOLD_LAST)     state_d = ST_WIN;
            else if (hold_cnt != HOLD_MAX) hold_d  = hold_cnt + 1'b1;
          end else begin
            hold_d = '0;
          end
        end
      end
      ST_WIN, ST_DEAD: begin
        if (press) state_d = ST_START;
      end
      default: begin
        state_d = ST_START;
        hold_d  = '0;
      end
    endcase
  end

  assign status = state;

`ifdef GAME_TIMER_EN
  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  logic [FW-1:0] frame_cnt;
  logic [9:0]    sec_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      sec_cnt   <= '0;
    end else if (game_reset) begin
      frame_cnt <= '0;
      sec_cnt   <= '0;
    end else if (state == ST_PLAY && tick) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        if (sec_cnt != 10'd999) sec_cnt <= sec_cnt + 10'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign play_seconds = sec_cnt;
`else
  assign play_seconds = '0;
`endif

endmodule
